// File: rtl/rtr_route_info_gen.sv
// rtl/rtr_route_info_gen.sv - injection-side phased dimension-order routing header generator
//
// Builds the per-resource-class dest_info field for each accepted packet request.
// Resource classes 0..R-2 get intermediate router addresses. Class R-1 gets the
// destination router address. The destination node address trails the field.
// Results sit in a single output holding stage with a valid/ready handshake.
//
// Optional feature macro: ROUTE_INFO_RANDOM_EN
//   defined   - intermediates come from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
//   undefined - no LFSR; every intermediate equals the destination router address
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   router_address    this router's address (static)
//   req_valid/ready   request handshake; req_dest_addr = {router addr, node addr}, req_mc one-hot
//   out_valid/ready   output handshake
//   out_dest_info     {addr class 0 .. addr class R-1, node addr}, class 0 in the top bits
//   out_sel_irc       initial resource class, one-hot, class 0 in the top bit
//   out_mc            registered copy of req_mc
module rtr_route_info_gen #(
    parameter int          num_message_classes  = 2,
    parameter int          num_resource_classes = 2,
    parameter int          num_routers_per_dim  = 4,
    parameter int          num_dimensions       = 2,
    parameter int          num_nodes_per_router = 1,
    parameter logic [15:0] lfsr_seed            = 16'h1ACE,
    localparam int dim_addr_width    = $clog2(num_routers_per_dim),
    localparam int router_addr_width = num_dimensions * dim_addr_width,
    localparam int node_addr_width   = $clog2(num_nodes_per_router),
    localparam int addr_width        = router_addr_width + node_addr_width,
    localparam int dest_info_width   = num_resource_classes * router_addr_width + node_addr_width
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [router_addr_width-1:0]    router_address,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [addr_width-1:0]           req_dest_addr,
    input  logic [num_message_classes-1:0]  req_mc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [dest_info_width-1:0]      out_dest_info,
    output logic [num_resource_classes-1:0] out_sel_irc,
    output logic [num_message_classes-1:0]  out_mc
);

    localparam int rc = num_resource_classes;
    localparam int rw = router_addr_width;
    localparam int dw = dim_addr_width;

    // Packets always start in resource class 0, which is the top bit.
    localparam logic [rc-1:0] irc_class0 = rc'(1) << (rc - 1);

    logic                       accept;
    logic [rw-1:0]              dest_router;
    logic [rc*rw-1:0]           addr_slots;
    logic [dest_info_width-1:0] dest_info_next;
    logic                       unused_router_address;

    assign req_ready   = ~out_valid | out_ready;
    assign accept      = req_valid & req_ready;
    assign dest_router = req_dest_addr[addr_width-1 -: rw];

    // The router address is not needed when intermediates are not randomized.
    assign unused_router_address = ^router_address;

    // The final class always routes straight to the destination router.
    assign addr_slots[rw-1:0] = dest_router;

    generate
        if (node_addr_width > 0) begin : g_node
            assign dest_info_next = {addr_slots, req_dest_addr[node_addr_width-1:0]};
        end else begin : g_no_node
            assign dest_info_next = addr_slots;
        end
    endgenerate

`ifdef ROUTE_INFO_RANDOM_EN
    logic [15:0] lfsr;
    logic        lfsr_feedback;
    logic        local_dest;

    // Shift toward the MSB and insert the feedback at the LSB.
    // Bit 15 here is the first LFSR bit handed out to intermediates.
    assign lfsr_feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign local_dest    = (dest_router == router_address);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= lfsr_seed;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_feedback};
        end
    end

    for (genvar k = 0; k < rc - 1; k++) begin : g_inter
        logic [rw-1:0] raw;
        logic [rw-1:0] wrapped;

        // Intermediate k takes the k-th router-width chunk from the top of the pre-advance LFSR.
        assign raw = lfsr[15 - k*rw -: rw];

        // One subtraction is enough. A dim field is below 2^dw <= 2*num_routers_per_dim.
        always_comb begin
            wrapped = raw;
            for (int d = 0; d < num_dimensions; d++) begin
                if (int'(raw[d*dw +: dw]) >= num_routers_per_dim) begin
                    wrapped[d*dw +: dw] = raw[d*dw +: dw] - dw'(num_routers_per_dim);
                end
            end
        end

        // A local destination must never leave the router, so it skips randomization.
        assign addr_slots[(rc-1-k)*rw +: rw] = local_dest ? dest_router : wrapped;
    end
`else
    for (genvar k = 0; k < rc - 1; k++) begin : g_inter
        assign addr_slots[(rc-1-k)*rw +: rw] = dest_router;
    end
`endif

    // Single holding stage. A drain and a new accept in the same cycle reload the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_dest_info <= '0;
            out_sel_irc   <= '0;
            out_mc        <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_dest_info <= dest_info_next;
            out_sel_irc   <= irc_class0;
            out_mc        <= req_mc;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtr_route_info_gen.sv
// tb/tb_rtr_route_info_gen.sv - directed self-checking bench for rtr_route_info_gen
module tb_rtr_route_info_gen;

`ifdef ROUTE_INFO_RANDOM_EN
    localparam bit random_en = 1'b1;
`else
    localparam bit random_en = 1'b0;
`endif
    localparam logic [15:0] seed = 16'h1ACE;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0] ra;
    logic       req_valid, req_ready, out_valid, out_ready;
    logic [3:0] req_dest_addr;
    logic [1:0] req_mc, out_sel_irc, out_mc;
    logic [7:0] out_dest_info;

    logic [3:0] ra3;
    logic       req_valid3, req_ready3, out_valid3, out_ready3;
    logic [3:0] req_dest_addr3;
    logic [1:0] req_mc3, out_sel_irc3, out_mc3;
    logic [7:0] out_dest_info3;

    rtr_route_info_gen dut (
        .clk(clk), .reset(rst_n), .router_address(ra),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_addr(req_dest_addr), .req_mc(req_mc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dest_info(out_dest_info), .out_sel_irc(out_sel_irc), .out_mc(out_mc)
    );

    rtr_route_info_gen #(.num_routers_per_dim(3)) dut3 (
        .clk(clk), .reset(rst_n), .router_address(ra3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_dest_addr(req_dest_addr3), .req_mc(req_mc3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_dest_info(out_dest_info3), .out_sel_irc(out_sel_irc3), .out_mc(out_mc3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Expected {intermediate, final} for a 2-dim, 2-class, 4-bit router address.
    function automatic logic [7:0] exp_info(input logic [3:0] r, input logic [3:0] d,
                                            input logic [15:0] s, input int n);
        logic [3:0] m;
        logic [1:0] f;
        m = d;
        if (random_en && d != r) begin
            m = s[15:12];
            for (int k = 0; k < 2; k++) begin
                f = m[k*2 +: 2];
                if (int'(f) >= n) f = f - 2'(n);
                m[k*2 +: 2] = f;
            end
        end
        return {m, d};
    endfunction

    typedef struct {
        logic [7:0] info;
        logic [1:0] mc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model_lfsr;
    int          n_acc = 0;
    int          n_drn = 0;

    // One cycle on dut: drive at negedge, score both handshakes, return 1 time unit after posedge.
    task automatic step(input logic v, input logic [3:0] d, input logic [1:0] mc, input logic ordy);
        exp_t e;
        @(negedge clk);
        req_valid     = v;
        req_dest_addr = d;
        req_mc        = mc;
        out_ready     = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_drn++;
            check_value("drain_has_entry", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check_value("drain_info", 32'(out_dest_info), 32'(e.info));
                check_value("drain_mc", 32'(out_mc), 32'(e.mc));
                check_value("drain_irc", 32'(out_sel_irc), 32'h2);
            end
        end
        if (req_valid && req_ready) begin
            e.info = exp_info(ra, d, model_lfsr, 4);
            e.mc   = mc;
            q.push_back(e);
            model_lfsr = lfsr_next(model_lfsr);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] model3;
        logic [7:0]  pend3;
        logic        have3;
        logic [3:0]  d3;

        rst_n = 1'b0;
        ra = 4'b0000; req_valid = 1'b0; req_dest_addr = '0; req_mc = '0; out_ready = 1'b0;
        ra3 = 4'b0110; req_valid3 = 1'b0; req_dest_addr3 = '0; req_mc3 = '0; out_ready3 = 1'b0;
        model_lfsr = seed;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_req_ready", 32'(req_ready), 32'd1);
        check_value("rst_dest_info", 32'(out_dest_info), 32'd0);
        check_value("rst_sel_irc", 32'(out_sel_irc), 32'd0);
        check_value("rst_mc", 32'(out_mc), 32'd0);
        check_value("rst_out_valid3", 32'(out_valid3), 32'd0);

        // First request. Intermediate = top nibble of seed 1ACE = 0001.
        step(1'b1, 4'b1011, 2'b01, 1'b0);
        check_value("lat1_valid", 32'(out_valid), 32'd1);
        check_value("first_info", 32'(out_dest_info), random_en ? 32'h1B : 32'hBB);
        check_value("first_irc", 32'(out_sel_irc), 32'h2);
        check_value("first_mc", 32'(out_mc), 32'h1);
        step(1'b0, 4'b0000, 2'b00, 1'b1);
        check_value("drain_clear", 32'(out_valid), 32'd0);

        // Local bypass. LFSR still advances, to 359D.
        ra = 4'b0110;
        step(1'b1, 4'b0110, 2'b10, 1'b1);
        check_value("bypass_info", 32'(out_dest_info), 32'h66);
        ra = 4'b0000;
        // Drain and reload in the same cycle. LFSR is now 6B3B, giving intermediate 0110.
        step(1'b1, 4'b1011, 2'b01, 1'b1);
        check_value("reload_valid", 32'(out_valid), 32'd1);
        check_value("adv_after_bypass", 32'(out_dest_info), random_en ? 32'h6B : 32'hBB);
        step(1'b0, 4'b0000, 2'b00, 1'b1);

        // Backpressure: A is held and B waits.
        step(1'b1, 4'b0111, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1101, 2'b10, 1'b0);
            check_value("bp_valid", 32'(out_valid), 32'd1);
            check_value("bp_ready", 32'(req_ready), 32'd0);
            check_value("bp_hold_info", 32'(out_dest_info), 32'(q[0].info));
            check_value("bp_hold_mc", 32'(out_mc), 32'h1);
            check_value("bp_no_accept", 32'(q.size()), 32'd1);
        end
        step(1'b1, 4'b1101, 2'b10, 1'b1);
        check_value("bp_release_q", 32'(q.size()), 32'd1);
        check_value("bp_release_info", 32'(out_dest_info), 32'(q[0].info));
        check_value("bp_release_mc", 32'(out_mc), 32'h2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (3) step(1'b0, 4'b0000, 2'b00, 1'b1);
        check_value("rand_acc_eq_drn", 32'(n_acc), 32'(n_drn));
        check_value("rand_q_empty", 32'(q.size()), 32'd0);

        // Reset while an entry is held. The entry is dropped and the LFSR reseeds.
        step(1'b1, 4'b1011, 2'b01, 1'b0);
        check_value("mid_held", 32'(out_valid), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_info", 32'(out_dest_info), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        model_lfsr = seed;
        step(1'b1, 4'b1011, 2'b01, 1'b1);
        check_value("reseed_info", 32'(out_dest_info), random_en ? 32'h1B : 32'hBB);
        step(1'b0, 4'b0000, 2'b00, 1'b1);

        // Three routers per dimension: 1000 back-to-back requests on dut3.
        model3 = seed;
        have3  = 1'b0;
        pend3  = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            d3 = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            if (i % 8 == 0) d3 = ra3;
            req_valid3 = 1'b1; out_ready3 = 1'b1; req_dest_addr3 = d3;
            req_mc3 = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check_value("n3_ready", 32'(req_ready3), 32'd1);
            if (have3) begin
                check_value("n3_valid", 32'(out_valid3), 32'd1);
                check_value("n3_info", 32'(out_dest_info3), 32'(pend3));
                check_value("n3_dim1_range", 32'(out_dest_info3[7:6] < 2'd3), 32'd1);
                check_value("n3_dim0_range", 32'(out_dest_info3[5:4] < 2'd3), 32'd1);
            end
            pend3  = exp_info(ra3, d3, model3, 3);
            model3 = lfsr_next(model3);
            have3  = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        req_valid3 = 1'b0;
        #1;
        check_value("n3_last_valid", 32'(out_valid3), 32'd1);
        check_value("n3_last_info", 32'(out_dest_info3), 32'(pend3));
        check_value("n3_last_irc", 32'(out_sel_irc3), 32'h2);
        @(posedge clk);
        #1;
        check_value("n3_drained", 32'(out_valid3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
